// File: rtl/edp_mpy_seq.sv
// Radix-2 shift-and-add multiply microsequencer driving EDP AD/AR/ARX/BR/MQ controls.
// Optional signed correction step compiled in with `define EDP_MPY_SIGNED_EN.
module edp_mpy_seq #(
    parameter int unsigned STEPS    = 36,
    parameter int unsigned CNTW     = 6,
    parameter logic [3:0]  AD_A     = 4'd0,
    parameter logic [3:0]  AD_APB   = 4'd6,
    parameter logic [3:0]  AD_AMB   = 4'd9,
    parameter logic [2:0]  SEL_ADX2 = 3'd2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_signed_mpy,
    input  logic            i_mplier_sign,
    input  logic            i_mq_bit35,
    output logic            o_busy,
    output logic            o_done,
    output logic [CNTW-1:0] o_step_count,
    output logic [3:0]      o_ad_sel,
    output logic [1:0]      o_ada_sel,
    output logic [1:0]      o_adb_sel,
    output logic            o_ad_bool,
    output logic            o_ad_long,
    output logic [2:0]      o_arl_sel,
    output logic [2:0]      o_arr_sel,
    output logic [2:0]      o_arxl_sel,
    output logic [2:0]      o_arxr_sel,
    output logic            o_ar00to08_load,
    output logic            o_ar09to17_load,
    output logic            o_arr_load,
    output logic            o_arx_load,
    output logic            o_br_load,
    output logic            o_ar00to11_clr,
    output logic            o_ar12to17_clr,
    output logic            o_arr_clr,
    output logic [1:0]      o_mq_sel
);

    typedef enum logic [2:0] {StIdle, StInit, StStep, StFix, StDone} state_e;

    state_e          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_ad_sel;
    logic            r_ad_long;
    logic [2:0]      r_sel;
    logic            r_ar_load;
    logic            r_arx_load;
    logic            r_br_load;
    logic            r_clr;
    logic [1:0]      r_mq_sel;

`ifdef EDP_MPY_SIGNED_EN
    logic            r_sign;
`else
    logic            w_unused_sign;
    assign w_unused_sign = ^{i_signed_mpy, i_mplier_sign};
`endif

    // Output registers hold the controls for the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ad_sel   <= 4'd0;
            r_ad_long  <= 1'b0;
            r_sel      <= 3'd0;
            r_ar_load  <= 1'b0;
            r_arx_load <= 1'b0;
            r_br_load  <= 1'b0;
            r_clr      <= 1'b0;
            r_mq_sel   <= 2'd0;
`ifdef EDP_MPY_SIGNED_EN
            r_sign     <= 1'b0;
`endif
        end else begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ad_sel   <= 4'd0;
            r_ad_long  <= 1'b0;
            r_sel      <= 3'd0;
            r_ar_load  <= 1'b0;
            r_arx_load <= 1'b0;
            r_br_load  <= 1'b0;
            r_clr      <= 1'b0;
            r_mq_sel   <= 2'd0;
            if (r_state != StIdle && i_abort) begin
                r_state <= StIdle;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start && !i_abort) begin
                            r_state   <= StInit;
                            r_busy    <= 1'b1;
                            r_br_load <= 1'b1;
                            r_clr     <= 1'b1;
                            r_mq_sel  <= 2'd1;
                        end
                    end
                    StInit: begin
                        r_state    <= StStep;
                        r_cnt      <= CNTW'(STEPS);
`ifdef EDP_MPY_SIGNED_EN
                        r_sign     <= i_mplier_sign;
`endif
                        r_busy     <= 1'b1;
                        r_ad_sel   <= AD_A;
                        r_ad_long  <= 1'b1;
                        r_sel      <= SEL_ADX2;
                        r_ar_load  <= 1'b1;
                        r_arx_load <= 1'b1;
                        r_mq_sel   <= 2'd2;
                    end
                    StStep: begin
                        r_cnt <= r_cnt - CNTW'(1);
                        if (r_cnt == CNTW'(1)) begin
`ifdef EDP_MPY_SIGNED_EN
                            r_state <= StFix;
                            r_busy  <= 1'b1;
                            if (i_signed_mpy && r_sign) begin
                                r_ad_sel  <= AD_AMB;
                                r_ar_load <= 1'b1;
                            end
`else
                            r_state <= StDone;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_busy     <= 1'b1;
                            r_ad_sel   <= AD_A;
                            r_ad_long  <= 1'b1;
                            r_sel      <= SEL_ADX2;
                            r_ar_load  <= 1'b1;
                            r_arx_load <= 1'b1;
                            r_mq_sel   <= 2'd2;
                        end
                    end
`ifdef EDP_MPY_SIGNED_EN
                    StFix: begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
`endif
                    StDone:  r_state <= StIdle;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    // Add/no-add decision follows the live multiplier LSB within the step cycle.
    assign o_ad_sel        = (r_state == StStep && i_mq_bit35) ? AD_APB : r_ad_sel;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_step_count    = r_cnt;
    assign o_ada_sel       = 2'd0;
    assign o_adb_sel       = 2'd0;
    assign o_ad_bool       = 1'b0;
    assign o_ad_long       = r_ad_long;
    assign o_arl_sel       = r_sel;
    assign o_arr_sel       = r_sel;
    assign o_arxl_sel      = r_sel;
    assign o_arxr_sel      = r_sel;
    assign o_ar00to08_load = r_ar_load;
    assign o_ar09to17_load = r_ar_load;
    assign o_arr_load      = r_ar_load;
    assign o_arx_load      = r_arx_load;
    assign o_br_load       = r_br_load;
    assign o_ar00to11_clr  = r_clr;
    assign o_ar12to17_clr  = r_clr;
    assign o_arr_clr       = r_clr;
    assign o_mq_sel        = r_mq_sel;

endmodule

// File: tb/tb_edp_mpy_seq.sv
// Bench for edp_mpy_seq: behavioural EDP model driven by the sequencer's controls,
// products checked against plain arithmetic multiplication.
module tb_edp_mpy_seq;

    localparam int unsigned STEPS = 36;
`ifdef EDP_MPY_SIGNED_EN
    localparam int LAT = STEPS + 3;
`else
    localparam int LAT = STEPS + 2;
`endif

    logic clk = 1'b0;
    logic rst_n, start, abort, signed_mpy, mplier_sign, mq_bit35;
    logic busy, done, ad_bool, ad_long;
    logic [5:0] step_count;
    logic [3:0] ad_sel;
    logic [1:0] ada_sel, adb_sel, mq_sel;
    logic [2:0] arl_sel, arr_sel, arxl_sel, arxr_sel;
    logic ar0008_ld, ar0917_ld, arr_ld, arx_ld, br_ld, ar0011_clr, ar1217_clr, arr_clr;

    always #5 clk = ~clk;

    edp_mpy_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_signed_mpy(signed_mpy), .i_mplier_sign(mplier_sign), .i_mq_bit35(mq_bit35),
        .o_busy(busy), .o_done(done), .o_step_count(step_count), .o_ad_sel(ad_sel),
        .o_ada_sel(ada_sel), .o_adb_sel(adb_sel), .o_ad_bool(ad_bool), .o_ad_long(ad_long),
        .o_arl_sel(arl_sel), .o_arr_sel(arr_sel), .o_arxl_sel(arxl_sel), .o_arxr_sel(arxr_sel),
        .o_ar00to08_load(ar0008_ld), .o_ar09to17_load(ar0917_ld), .o_arr_load(arr_ld),
        .o_arx_load(arx_ld), .o_br_load(br_ld), .o_ar00to11_clr(ar0011_clr),
        .o_ar12to17_clr(ar1217_clr), .o_arr_clr(arr_clr), .o_mq_sel(mq_sel)
    );

    logic [39:0] ctl;
    assign ctl = {busy, done, step_count, ad_sel, ada_sel, adb_sel, ad_bool, ad_long,
                  arl_sel, arr_sel, arxl_sel, arxr_sel, ar0008_ld, ar0917_ld, arr_ld,
                  arx_ld, br_ld, ar0011_clr, ar1217_clr, arr_clr, mq_sel};

    // Behavioural EDP: AR, ARX, BR, MQ and a 38-bit AD.
    logic [35:0] ar, arx, br, mq, mpl_in, tb_ar_val;
    logic        tb_signed, tb_load;
    logic [37:0] m_a, m_b, m_ad;
    logic [35:0] m_src_l, m_src_r;
    int n_step = 0, n_apb = 0, n_amb = 0, n_done = 0;

    assign mq_bit35 = mq[0];

    always_comb begin
        m_a = tb_signed ? {{2{ar[35]}}, ar} : {2'b00, ar};
        m_b = tb_signed ? {{2{br[35]}}, br} : {2'b00, br};
        case (ad_sel)
            4'd6:    m_ad = m_a + m_b;
            4'd9:    m_ad = m_a - m_b;
            default: m_ad = m_a;
        endcase
        m_src_l = (arl_sel == 3'd2) ? m_ad[36:1] : m_ad[35:0];
        m_src_r = (arr_sel == 3'd2) ? m_ad[36:1] : m_ad[35:0];
    end

    always @(posedge clk) begin
        if (tb_load) begin
            ar <= tb_ar_val;
        end else begin
            ar[35:27] <= ar0011_clr ? 9'd0 : ar0008_ld ? m_src_l[35:27] : ar[35:27];
            ar[26:24] <= ar0011_clr ? 3'd0 : ar0917_ld ? m_src_l[26:24] : ar[26:24];
            ar[23:18] <= ar1217_clr ? 6'd0 : ar0917_ld ? m_src_l[23:18] : ar[23:18];
            ar[17:0]  <= arr_clr ? 18'd0 : arr_ld ? m_src_r[17:0] : ar[17:0];
        end
        if (arx_ld && arxl_sel == 3'd2) arx <= {m_ad[0], arx[35:1]};
        if (br_ld) br <= ar;
        if (mq_sel == 2'd1) mq <= mpl_in;
        else if (mq_sel == 2'd2) mq <= {1'b0, mq[35:1]};
        if (ad_long) n_step <= n_step + 1;
        if (ad_long && ad_sel == 4'd6) n_apb <= n_apb + 1;
        if (ad_sel == 4'd9) n_amb <= n_amb + 1;
        if (done) n_done <= n_done + 1;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount(input logic [35:0] v);
        int c = 0;
        for (int i = 0; i < 36; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic run_mul(input logic [35:0] mc, input logic [35:0] mp, input logic sgn,
                           input string tag);
        logic [71:0] exp;
        int cyc, s0, a0, m0;
        int exp_amb = 0;
        @(negedge clk);
        tb_signed = sgn; signed_mpy = sgn; mplier_sign = mp[35];
        tb_ar_val = mc; tb_load = 1'b1; mpl_in = mp; start = 1'b1;
        s0 = n_step; a0 = n_apb; m0 = n_amb;
        @(posedge clk); #1;
        start = 1'b0; tb_load = 1'b0; cyc = 1;
        check({tag, ".init"}, 72'({busy, br_ld, ar0011_clr, mq_sel, step_count}),
              72'({1'b1, 1'b1, 1'b1, 2'd1, 6'd0}));
        while (!done && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 2) check({tag, ".cnt0"}, 72'(step_count), 72'(STEPS));
        end
        check({tag, ".lat"}, 72'(cyc), 72'(LAT));
        if (sgn) exp = {{36{mc[35]}}, mc} * {{36{mp[35]}}, mp};
        else     exp = 72'(mc) * 72'(mp);
        check({tag, ".prod"}, {ar, arx}, exp);
        check({tag, ".nstep"}, 72'(n_step - s0), 72'(STEPS));
        check({tag, ".napb"}, 72'(n_apb - a0), 72'(popcount(mp)));
`ifdef EDP_MPY_SIGNED_EN
        exp_amb = (sgn && mp[35]) ? 1 : 0;
`endif
        check({tag, ".namb"}, 72'(n_amb - m0), 72'(exp_amb));
        @(posedge clk); #1;
        check({tag, ".post"}, 72'({done, busy}), 72'(0));
    endtask

    initial begin
        int cyc, d0;
        int dq[$];
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; signed_mpy = 1'b0; mplier_sign = 1'b0;
        tb_signed = 1'b0; tb_load = 1'b0; tb_ar_val = '0; mpl_in = '0;
        ar = '0; arx = '0; br = '0; mq = '0;
        #12;
        check("reset.ctl", 72'(ctl), 72'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.ctl", 72'(ctl), 72'(0));

        run_mul(36'd5, 36'd3, 1'b0, "u5x3");
        run_mul(36'o777777777777, 36'o777777777777, 1'b0, "umax");
        run_mul(36'd0, 36'd12345, 1'b0, "uzero");
        for (int i = 0; i < 4; i++)
            run_mul({4'($urandom_range(0, 15)), 32'($urandom)},
                    {4'($urandom_range(0, 15)), 32'($urandom)}, 1'b0, "urand");
`ifdef EDP_MPY_SIGNED_EN
        run_mul(-36'sd3, 36'sd7, 1'b1, "sm3x7");
        run_mul(36'sd7, -36'sd3, 1'b1, "s7xm3");
        run_mul(-36'sd5, -36'sd9, 1'b1, "sm5xm9");
        for (int i = 0; i < 3; i++)
            run_mul({4'($urandom_range(0, 15)), 32'($urandom)},
                    {4'($urandom_range(0, 15)), 32'($urandom)}, 1'b1, "srand");
`endif

        // Abort in the 10th step cycle.
        @(negedge clk);
        tb_signed = 1'b0; signed_mpy = 1'b0; tb_ar_val = 36'd77; tb_load = 1'b1;
        mpl_in = 36'd99; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; tb_load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort.instep", 72'({busy, ad_long}), 72'({1'b1, 1'b1}));
        @(negedge clk); abort = 1'b1; d0 = n_done;
        @(posedge clk); #1; abort = 1'b0;
        check("abort.ctl", 72'(ctl), 72'(0));
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("abort.nodone", 72'(n_done - d0), 72'(0));
        run_mul(36'd1000, 36'd1001, 1'b0, "postabort");

        // Asynchronous reset in the middle of stepping.
        @(negedge clk);
        tb_ar_val = 36'd3; tb_load = 1'b1; mpl_in = 36'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; tb_load = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("rstmid.ctl", 72'(ctl), 72'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid.idle", 72'({busy, step_count}), 72'(0));
        run_mul(36'd123456, 36'd654321, 1'b0, "postrst");

        // Start held continuously: done period is LAT plus one idle cycle.
        @(negedge clk);
        tb_signed = 1'b0; signed_mpy = 1'b0; tb_ar_val = 36'd9; tb_load = 1'b1;
        mpl_in = 36'd11; start = 1'b1;
        @(posedge clk); #1; tb_load = 1'b0; cyc = 1;
        while (cyc < 3 * LAT + 2) begin
            @(posedge clk); #1; cyc++;
            if (done) dq.push_back(cyc);
        end
        @(negedge clk); start = 1'b0;
        check("held.ndone", 72'(dq.size()), 72'(3));
        for (int i = 0; i < dq.size() && i < 3; i++)
            check("held.when", 72'(dq[i]), 72'(LAT + i * (LAT + 1)));

        // start and abort together in IDLE.
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("startabort.ctl", 72'(ctl), 72'(0));
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("startabort.idle", 72'(busy), 72'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
